free_list_ctrl: RTL and testbench

- Allocation controller in front of the physical-register free list in the 2-wide out-of-order core.
- Tracks the free-tag count and grants 0–2 tags per cycle to dispatch, counting same-cycle retire forwarding as available.
- Stalls dispatch on shortage and sequences mispredict recovery: it tells the free list to rewind, then blanks grants until recovery completes.

---
 rtl/free_list_ctrl_pkg.sv | 21 ++
 rtl/free_list_ctrl_grant_calc.sv | 37 +++
 rtl/free_list_ctrl.sv | 148 ++++++++++++++
 tb/tb_free_list_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/free_list_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the physical-register allocation controller.
package free_list_ctrl_pkg;

  localparam int TAG_W       = 7;
  localparam int NUM_PREGS   = 96;
  localparam int NUM_AREGS   = 32;
  localparam int FREE_MAX    = NUM_PREGS - NUM_AREGS;
  localparam int ISSUE_WIDTH = 2;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    REWIND = 2'd1,
    BLANK  = 2'd2
  } fl_state_t;

  // Dispatch and retire are 2-wide; an encoding of 3 behaves as the full width.
  function automatic logic [1:0] sat_issue(input logic [1:0] v);
    return (v > 2'(ISSUE_WIDTH)) ? 2'(ISSUE_WIDTH) : v;
  endfunction

endpackage

// File: rtl/free_list_ctrl_grant_calc.sv
// Combinational grant/next-count evaluation for the RUN state of free_list_ctrl.
module fl_grant_calc #(
  parameter int CNT_W     = 7,
  parameter int MAX_COUNT = 64
) (
  input  logic [1:0]       req,
  input  logic [1:0]       retire,
  input  logic [CNT_W-1:0] count,
  output logic [1:0]       grant,
  output logic             stall,
  output logic [CNT_W-1:0] next_count,
  output logic             overflow
);
  import free_list_ctrl_pkg::*;

  logic [1:0]     req_eff;
  logic [1:0]     ret_eff;
  logic [CNT_W:0] avail;
  logic [CNT_W:0] sum;

  always_comb begin
    req_eff = sat_issue(req);
    ret_eff = sat_issue(retire);
    // Retiring tags are forwarded by the free list, so they count as available now.
    avail = {1'b0, count} + (CNT_W+1)'(ret_eff);
    if (avail < (CNT_W+1)'(req_eff)) begin
      grant = avail[1:0];
    end else begin
      grant = req_eff;
    end
    stall      = (grant < req_eff);
    sum        = avail - (CNT_W+1)'(grant);
    overflow   = (sum > (CNT_W+1)'(MAX_COUNT));
    next_count = overflow ? CNT_W'(MAX_COUNT) : sum[CNT_W-1:0];
  end

endmodule

// File: rtl/free_list_ctrl.sv
// Free-list allocation controller: grants 0-2 tags per cycle and sequences mispredict recovery.
// Optional FL_STATS_EN adds stall-cycle and free-count low-water statistics.
//
// state  | meaning
// RUN    | normal allocation, grants from free count plus same-cycle retires
// REWIND | one-cycle fl_rewind pulse, free count reloaded to full
// BLANK  | grants suppressed for RECOVER_CYCLES cycles
module free_list_ctrl #(
  parameter int NUM_PREGS      = 96,
  parameter int NUM_AREGS      = 32,
  parameter int CNT_W          = 7,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       id_req_num,
  input  logic [1:0]       rob_retire_num,
  input  logic             rob_flush,
  output logic [1:0]       fl_alloc_num,
  output logic             fl_rewind,
  output logic             id_stall,
  output logic [CNT_W-1:0] fl_free_count,
  output logic             fl_overflow_err
`ifdef FL_STATS_EN
  ,
  output logic [15:0]      stat_stall_cycles,
  output logic [CNT_W-1:0] stat_min_free
`endif
);
  import free_list_ctrl_pkg::*;

  localparam int FL_FREE_MAX = NUM_PREGS - NUM_AREGS;

  fl_state_t        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic [2:0]       blank_q, blank_d;

  logic [1:0]       calc_req;
  logic [1:0]       calc_grant;
  logic             calc_stall;
  logic [CNT_W-1:0] calc_next;
  logic             calc_ovf;

  logic [1:0]       alloc;
  logic             rewind;
  logic             stall;

  fl_grant_calc #(
    .CNT_W    (CNT_W),
    .MAX_COUNT(FL_FREE_MAX)
  ) u_grant_calc (
    .req       (calc_req),
    .retire    (rob_retire_num),
    .count     (count_q),
    .grant     (calc_grant),
    .stall     (calc_stall),
    .next_count(calc_next),
    .overflow  (calc_ovf)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    err_d    = err_q;
    blank_d  = blank_q;
    calc_req = 2'd0;
    alloc    = 2'd0;
    rewind   = 1'b0;
    stall    = 1'b1;
    unique case (state_q)
      RUN: begin
        // A flush zeroes the request but older retires still return their tags.
        calc_req = rob_flush ? 2'd0 : id_req_num;
        alloc    = calc_grant;
        stall    = rob_flush | calc_stall;
        count_d  = calc_next;
        err_d    = err_q | calc_ovf;
        if (rob_flush) state_d = REWIND;
      end
      REWIND: begin
        rewind  = 1'b1;
        count_d = CNT_W'(FL_FREE_MAX);
        blank_d = 3'(RECOVER_CYCLES);
        state_d = rob_flush ? REWIND : BLANK;
      end
      BLANK: begin
        if (rob_flush) begin
          state_d = REWIND;
        end else begin
          blank_d = blank_q - 3'd1;
          if (blank_q <= 3'd1) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= RUN;
      count_q <= CNT_W'(FL_FREE_MAX);
      err_q   <= 1'b0;
      blank_q <= 3'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      blank_q <= blank_d;
    end
  end

  assign fl_alloc_num    = reset ? alloc : 2'd0;
  assign fl_rewind       = reset & rewind;
  assign id_stall        = ~reset | stall;
  assign fl_free_count   = count_q;
  assign fl_overflow_err = err_q;

`ifdef FL_STATS_EN
  logic [15:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] min_free_q, min_free_d;
  logic             run_stall;

  always_comb begin
    // Recovery stalls, including the flush cycle itself, are not counted.
    run_stall   = (state_q == RUN) && !rob_flush && calc_stall;
    stall_cnt_d = stall_cnt_q;
    if (run_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    min_free_d  = (count_d < min_free_q) ? count_d : min_free_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cnt_q <= 16'd0;
      min_free_q  <= CNT_W'(FL_FREE_MAX);
    end else begin
      stall_cnt_q <= stall_cnt_d;
      min_free_q  <= min_free_d;
    end
  end

  assign stat_stall_cycles = stall_cnt_q;
  assign stat_min_free     = min_free_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_free_list_ctrl.sv
module tb_free_list_ctrl;

   logic       clock;
   logic       reset;
   logic [1:0] id_req_num;
   logic [1:0] rob_retire_num;
   logic       rob_flush;
   logic [1:0] fl_alloc_num;
   logic       fl_rewind;
   logic       id_stall;
   logic [6:0] fl_free_count;
   logic       fl_overflow_err;
`ifdef FL_STATS_EN
   logic [15:0] stat_stall_cycles;
   logic [6:0]  stat_min_free;
`endif

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   free_list_ctrl dut (
      .clock          (clock),
      .reset          (reset),
      .id_req_num     (id_req_num),
      .rob_retire_num (rob_retire_num),
      .rob_flush      (rob_flush),
      .fl_alloc_num   (fl_alloc_num),
      .fl_rewind      (fl_rewind),
      .id_stall       (id_stall),
      .fl_free_count  (fl_free_count),
      .fl_overflow_err(fl_overflow_err)
`ifdef FL_STATS_EN
      ,
      .stat_stall_cycles(stat_stall_cycles),
      .stat_min_free    (stat_min_free)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b0; id_req_num = 2'd0; rob_retire_num = 2'd0; rob_flush = 1'b0;
      tick();
      tick();
      id_req_num = 2'd2;
      @(negedge clock);
      chk("rst_alloc", 32'(fl_alloc_num), 32'd0);
      chk("rst_stall", 32'(id_stall), 32'd1);
      chk("rst_rewind", 32'(fl_rewind), 32'd0);
      chk("rst_count", 32'(fl_free_count), 32'd64);
      chk("rst_err", 32'(fl_overflow_err), 32'd0);
      tick();
      reset = 1'b1; id_req_num = 2'd0;
      @(negedge clock);
      tick();

      id_req_num = 2'd2;
      for (int i = 0; i < 32; i++) begin
         @(negedge clock);
         chk("drain_alloc", 32'(fl_alloc_num), 32'd2);
         chk("drain_stall", 32'(id_stall), 32'd0);
         chk("drain_count", 32'(fl_free_count), 32'(64 - 2 * i));
         tick();
      end
      @(negedge clock);
      chk("empty_alloc", 32'(fl_alloc_num), 32'd0);
      chk("empty_stall", 32'(id_stall), 32'd1);
      chk("empty_count", 32'(fl_free_count), 32'd0);
      tick();

      id_req_num = 2'd3; rob_retire_num = 2'd3;
      @(negedge clock);
      chk("fwd_alloc", 32'(fl_alloc_num), 32'd2);
      chk("fwd_stall", 32'(id_stall), 32'd0);
      tick();
      id_req_num = 2'd0; rob_retire_num = 2'd1;
      @(negedge clock);
      chk("fwd_count", 32'(fl_free_count), 32'd0);
      tick();
      id_req_num = 2'd2; rob_retire_num = 2'd0;
      @(negedge clock);
      chk("one_count", 32'(fl_free_count), 32'd1);
      chk("one_alloc", 32'(fl_alloc_num), 32'd1);
      chk("one_stall", 32'(id_stall), 32'd1);
      tick();
      id_req_num = 2'd0;
      @(negedge clock);
      chk("one_next", 32'(fl_free_count), 32'd0);
      tick();

      rob_retire_num = 2'd2;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         tick();
      end

      rob_flush = 1'b1; rob_retire_num = 2'd1; id_req_num = 2'd2;
      @(negedge clock);
      chk("fl_pre_count", 32'(fl_free_count), 32'd10);
      chk("fl_alloc", 32'(fl_alloc_num), 32'd0);
      chk("fl_stall", 32'(id_stall), 32'd1);
      chk("fl_rewind0", 32'(fl_rewind), 32'd0);
      tick();
      rob_flush = 1'b0; rob_retire_num = 2'd0;
      @(negedge clock);
      chk("rw_pulse", 32'(fl_rewind), 32'd1);
      chk("rw_count", 32'(fl_free_count), 32'd11);
      chk("rw_alloc", 32'(fl_alloc_num), 32'd0);
      tick();
      @(negedge clock);
      chk("b1_count", 32'(fl_free_count), 32'd64);
      chk("b1_rewind", 32'(fl_rewind), 32'd0);
      chk("b1_alloc", 32'(fl_alloc_num), 32'd0);
      chk("b1_stall", 32'(id_stall), 32'd1);
      tick();
      @(negedge clock);
      chk("b2_alloc", 32'(fl_alloc_num), 32'd0);
      chk("b2_stall", 32'(id_stall), 32'd1);
      tick();
      @(negedge clock);
      chk("rec_alloc", 32'(fl_alloc_num), 32'd2);
      chk("rec_stall", 32'(id_stall), 32'd0);
      tick();

      id_req_num = 2'd0; rob_retire_num = 2'd2;
      @(negedge clock);
      chk("ov_pre", 32'(fl_free_count), 32'd62);
      tick();
      @(negedge clock);
      chk("ov_full", 32'(fl_free_count), 32'd64);
      chk("ov_err0", 32'(fl_overflow_err), 32'd0);
      tick();
      rob_retire_num = 2'd0;
      @(negedge clock);
      chk("ov_clamp", 32'(fl_free_count), 32'd64);
      chk("ov_err1", 32'(fl_overflow_err), 32'd1);
      tick();
      @(negedge clock);
      chk("ov_sticky", 32'(fl_overflow_err), 32'd1);
      tick();

      rob_flush = 1'b1; id_req_num = 2'd2;
      @(negedge clock);
      chk("f2_alloc", 32'(fl_alloc_num), 32'd0);
      tick();
      rob_flush = 1'b0;
      @(negedge clock);
      chk("f2_rewind", 32'(fl_rewind), 32'd1);
      tick();
      rob_flush = 1'b1;
      @(negedge clock);
      chk("f2_blank_rw", 32'(fl_rewind), 32'd0);
      chk("f2_blank_st", 32'(id_stall), 32'd1);
      tick();
      rob_flush = 1'b0;
      @(negedge clock);
      chk("f2_restart", 32'(fl_rewind), 32'd1);
      chk("f2_rs_alloc", 32'(fl_alloc_num), 32'd0);
      tick();
      reset = 1'b0;
      @(negedge clock);
      chk("mid_rst_alloc", 32'(fl_alloc_num), 32'd0);
      chk("mid_rst_stall", 32'(id_stall), 32'd1);
      chk("mid_rst_rw", 32'(fl_rewind), 32'd0);
      tick();
      reset = 1'b1;
      @(negedge clock);
      chk("post_rst_alloc", 32'(fl_alloc_num), 32'd2);
      chk("post_rst_stall", 32'(id_stall), 32'd0);
      chk("post_rst_count", 32'(fl_free_count), 32'd64);
      chk("post_rst_err", 32'(fl_overflow_err), 32'd0);
      tick();
      @(negedge clock);
      chk("post_rst_next", 32'(fl_free_count), 32'd62);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
